game_ctrl: RTL and testbench

//  Frame-level sequencer for the brick-breaker datapath. Owns the registered game state
//  (bricks, ball position/velocity/direction, paddle x) and feeds it to the combinational

---
 rtl/game_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Frame-level sequencer for the brick-breaker datapath: owns the registered game state,
// commits physics results once per frame and runs serve/lives/score/win-lose flow.
module game_ctrl #(
  parameter int unsigned H          = 640,
  parameter int unsigned V          = 480,
  parameter int unsigned BOARD_W    = 96,
  parameter int unsigned BOARD_STEP = 8,
  parameter int unsigned VX0        = 3,
  parameter int unsigned VY0        = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned INIT_ROWS  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           btn_start,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic [1439:0]  nxt_bricks,
  input  logic [9:0]     nxt_ball_x,
  input  logic [9:0]     nxt_ball_y,
  input  logic [9:0]     nxt_ball_vx,
  input  logic [9:0]     nxt_ball_vy,
  input  logic [1:0]     nxt_ball_dir,
  output logic [1439:0]  bricks,
  output logic [9:0]     ball_x,
  output logic [9:0]     ball_y,
  output logic [9:0]     ball_vx,
  output logic [9:0]     ball_vy,
  output logic [1:0]     ball_dir,
  output logic [9:0]     board_x,
  output logic [1:0]     lives,
  output logic [8:0]     score,
  output logic [2:0]     state
);

  localparam int unsigned NumSlots  = 480;
  localparam int unsigned BoardTop  = V - 13;
  localparam int unsigned BallSize  = 10;

  localparam logic [9:0]  BoardMax  = 10'(H - BOARD_W);
  localparam logic [9:0]  BoardHi   = 10'(H - BOARD_W - BOARD_STEP);
  localparam logic [9:0]  BoardRst  = 10'((H - BOARD_W) / 2);
  localparam logic [9:0]  Step      = 10'(BOARD_STEP);
  localparam logic [9:0]  BallOfs   = 10'((BOARD_W - 16) / 2);
  localparam logic [9:0]  ServeY    = 10'(BoardTop - BallSize);
  localparam logic [10:0] MissY     = 11'(BoardTop + BallSize);
  localparam logic [9:0]  ServeVx   = 10'(VX0);
  localparam logic [9:0]  ServeVy   = 10'(VY0);
  localparam logic [1:0]  LivesRst  = 2'(LIVES);
  localparam logic [8:0]  InitCount = 9'(INIT_ROWS * 20);
  localparam logic [8:0]  LastSlot  = 9'(NumSlots - 1);

  function automatic logic [1439:0] init_map();
    logic [1439:0] m;
    m = '0;
    for (int i = 0; i < int'(NumSlots); i++) begin
      if (i < int'(INIT_ROWS * 20)) m[3*i +: 3] = 3'd1;
    end
    return m;
  endfunction

  localparam logic [1439:0] InitMap = init_map();

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StScan  = 3'd3,
    StWin   = 3'd4,
    StOver  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1439:0]   bricks_q, bricks_d;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]      ball_vx_q, ball_vx_d, ball_vy_q, ball_vy_d;
  logic [1:0]      ball_dir_q, ball_dir_d;
  logic [9:0]      board_q, board_d;
  logic [1:0]      lives_q, lives_d;
  logic [8:0]      score_q, score_d;
  logic [8:0]      scan_idx_q, scan_idx_d, scan_cnt_q, scan_cnt_d;
  logic            start_q;

  logic            start_edge;
  logic [9:0]      board_mv;
  logic            miss;
  logic [10:0]     slot_base;
  logic [2:0]      slot;
  logic [8:0]      cnt_inc;
  logic [8:0]      score_calc;

  assign start_edge = btn_start & ~start_q;
  assign miss       = nxt_ball_dir[0] && (({1'b0, nxt_ball_y} + 11'd10) > MissY);
  assign slot_base  = {2'b00, scan_idx_q} * 11'd3;
  assign slot       = bricks_q[slot_base +: 3];
  assign cnt_inc    = scan_cnt_q + {8'd0, |slot};
  assign score_calc = (cnt_inc >= InitCount) ? 9'd0 : InitCount - cnt_inc;

  always_comb begin
    board_mv = board_q;
    if (btn_left && !btn_right) begin
      board_mv = (board_q < Step) ? 10'd0 : board_q - Step;
    end else if (btn_right && !btn_left) begin
      board_mv = (board_q > BoardHi) ? BoardMax : board_q + Step;
    end
  end

  always_comb begin
    state_d    = state_q;
    bricks_d   = bricks_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    ball_vx_d  = ball_vx_q;
    ball_vy_d  = ball_vy_q;
    ball_dir_d = ball_dir_q;
    board_d    = board_q;
    lives_d    = lives_q;
    score_d    = score_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          bricks_d   = InitMap;
          lives_d    = LivesRst;
          score_d    = '0;
          ball_x_d   = board_q + BallOfs;
          ball_y_d   = ServeY;
          ball_vx_d  = '0;
          ball_vy_d  = '0;
          ball_dir_d = 2'b10;
          state_d    = StServe;
        end
      end
      StServe: begin
        if (frame_tick) begin
          board_d  = board_mv;
          ball_x_d = board_mv + BallOfs;
          ball_y_d = ServeY;
        end
        // Serve wins over the tick, but the ball still follows the moved paddle.
        if (start_edge) begin
          ball_vx_d  = ServeVx;
          ball_vy_d  = ServeVy;
          ball_dir_d = 2'b10;
          state_d    = StPlay;
        end
      end
      StPlay: begin
        if (frame_tick) begin
          board_d  = board_mv;
          bricks_d = nxt_bricks;
          if (miss) begin
            lives_d    = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            ball_x_d   = board_mv + BallOfs;
            ball_y_d   = ServeY;
            ball_vx_d  = '0;
            ball_vy_d  = '0;
            ball_dir_d = 2'b10;
            state_d    = (lives_q <= 2'd1) ? StOver : StServe;
          end else begin
            ball_x_d   = nxt_ball_x;
            ball_y_d   = nxt_ball_y;
            ball_vx_d  = nxt_ball_vx;
            ball_vy_d  = nxt_ball_vy;
            ball_dir_d = nxt_ball_dir;
            scan_idx_d = '0;
            scan_cnt_d = '0;
            state_d    = StScan;
          end
        end
      end
      StScan: begin
        scan_cnt_d = cnt_inc;
        if (scan_idx_q == LastSlot) begin
          score_d = score_calc;
          state_d = (cnt_inc == 9'd0) ? StWin : StPlay;
        end else begin
          scan_idx_d = scan_idx_q + 9'd1;
        end
      end
      StWin, StOver: begin
        if (start_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bricks_q   <= '0;
      ball_x_q   <= BoardRst + BallOfs;
      ball_y_q   <= ServeY;
      ball_vx_q  <= '0;
      ball_vy_q  <= '0;
      ball_dir_q <= 2'b10;
      board_q    <= BoardRst;
      lives_q    <= LivesRst;
      score_q    <= '0;
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bricks_q   <= bricks_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      ball_vx_q  <= ball_vx_d;
      ball_vy_q  <= ball_vy_d;
      ball_dir_q <= ball_dir_d;
      board_q    <= board_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      scan_idx_q <= scan_idx_d;
      scan_cnt_q <= scan_cnt_d;
      start_q    <= btn_start;
    end
  end

  assign bricks   = bricks_q;
  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign ball_vx  = ball_vx_q;
  assign ball_vy  = ball_vy_q;
  assign ball_dir = ball_dir_q;
  assign board_x  = board_q;
  assign lives    = lives_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a game-rules model queues the expected outputs for every
// state change, and a monitor compares them when the DUT's state moves.
module tb_game_ctrl;

  localparam int NSLOT = 480;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          frame_tick = 1'b0, btn_start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [1439:0] nxt_bricks = '0;
  logic [9:0]    nxt_ball_x = '0, nxt_ball_y = '0, nxt_ball_vx = '0, nxt_ball_vy = '0;
  logic [1:0]    nxt_ball_dir = '0;
  logic [1439:0] bricks;
  logic [9:0]    ball_x, ball_y, ball_vx, ball_vy, board_x;
  logic [1:0]    ball_dir, lives;
  logic [8:0]    score;
  logic [2:0]    state;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .btn_left(btn_left), .btn_right(btn_right), .nxt_bricks(nxt_bricks),
    .nxt_ball_x(nxt_ball_x), .nxt_ball_y(nxt_ball_y), .nxt_ball_vx(nxt_ball_vx),
    .nxt_ball_vy(nxt_ball_vy), .nxt_ball_dir(nxt_ball_dir), .bricks(bricks),
    .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy),
    .ball_dir(ball_dir), .board_x(board_x), .lives(lives), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic [1:0]    lv;
    logic [8:0]    sc;
    logic [9:0]    bd, bx, by, vx, vy;
    logic [1:0]    dir;
    logic [1439:0] br;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Game-rules model
  int m_slot[NSLOT];
  int m_state, m_lives, m_score, m_board, m_bx, m_by, m_vx, m_vy, m_dir;

  function automatic logic [1439:0] pack_model();
    logic [1439:0] p;
    p = '0;
    for (int i = 0; i < NSLOT; i++) p[3*i +: 3] = 3'(m_slot[i]);
    return p;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.st = 3'(m_state);  e.lv = 2'(m_lives); e.sc = 9'(m_score); e.bd = 10'(m_board);
    e.bx = 10'(m_bx);    e.by = 10'(m_by);   e.vx = 10'(m_vx);   e.vy = 10'(m_vy);
    e.dir = 2'(m_dir);   e.br = pack_model();
    return e;
  endfunction

  task automatic push_exp();
    exp_q.push_back(snapshot());
  endtask

  task automatic m_reset();
    foreach (m_slot[i]) m_slot[i] = 0;
    m_state = 0; m_board = 272; m_bx = 312; m_by = 457; m_vx = 0; m_vy = 0; m_dir = 2;
    m_lives = 3; m_score = 0;
  endtask

  task automatic m_new_game();
    foreach (m_slot[i]) m_slot[i] = (i < 120) ? 1 : 0;
    m_lives = 3; m_score = 0; m_bx = m_board + 40; m_by = 457; m_vx = 0; m_vy = 0; m_dir = 2;
    m_state = 1;
  endtask

  task automatic m_paddle(logic l, logic r);
    if (l && !r) m_board = (m_board - 8 < 0) ? 0 : m_board - 8;
    else if (r && !l) m_board = (m_board + 8 > 544) ? 544 : m_board + 8;
  endtask

  task automatic chk(string name, int unsigned act, int unsigned req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_rec(string tag, exp_t e);
    int bad;
    chk({tag, ".state"}, state, e.st);
    chk({tag, ".lives"}, lives, e.lv);
    chk({tag, ".score"}, score, e.sc);
    chk({tag, ".board_x"}, board_x, e.bd);
    chk({tag, ".ball_x"}, ball_x, e.bx);
    chk({tag, ".ball_y"}, ball_y, e.by);
    chk({tag, ".ball_vx"}, ball_vx, e.vx);
    chk({tag, ".ball_vy"}, ball_vy, e.vy);
    chk({tag, ".ball_dir"}, ball_dir, e.dir);
    n_tests++;
    if (bricks !== e.br) begin
      n_fail++;
      bad = 0;
      for (int i = NSLOT - 1; i >= 0; i--) if (bricks[3*i +: 3] !== e.br[3*i +: 3]) bad = i;
      $display("FAIL %s.bricks: slot %0d got %0d, expected %0d", tag, bad,
               bricks[3*bad +: 3], e.br[3*bad +: 3]);
    end
  endtask

  // Monitor: every change of state is an output event that must match the next expectation.
  initial begin
    logic [2:0] prev;
    exp_t       e;
    @(posedge rst_n);
    prev = state;
    forever begin
      @(negedge clk);
      if (state != prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_transition: state %0d -> %0d, nothing expected", prev, state);
        end else begin
          e = exp_q.pop_front();
          chk_rec($sformatf("transition_%0d_to_%0d", prev, state), e);
        end
        prev = state;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_press(logic with_tick);
    btn_start = 1'b1; frame_tick = with_tick;
    step();
    btn_start = 1'b0; frame_tick = 1'b0;
    step();
  endtask

  task automatic paddle_ticks(int n, int mode);
    logic l, r;
    for (int k = 0; k < n; k++) begin
      l = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      r = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      btn_left = l; btn_right = r;
      m_paddle(l, r);
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic serve(logic with_tick);
    logic l, r;
    l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
    btn_left = l; btn_right = r;
    if (with_tick) m_paddle(l, r);
    m_bx = m_board + 40; m_by = 457; m_vx = 3; m_vy = 4; m_dir = 2; m_state = 2;
    push_exp();
    start_press(with_tick);
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  // kind: 0 random hits, 1 clear all, 2 miss, 3 clear five fixed slots
  task automatic play_frame(int kind, int abort_at);
    int nb[NSLOT];
    int x, y, d, vx, vy, cnt, n, k;
    logic l, r, miss;
    nb = m_slot;
    x = $urandom_range(0, 1023); vx = $urandom_range(0, 1023); vy = $urandom_range(0, 1023);
    y = $urandom_range(0, 467);  d = $urandom_range(0, 3);
    case (kind)
      0: repeat ($urandom_range(1, 6)) begin
           k = $urandom_range(0, NSLOT - 1);
           nb[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         end
      1: foreach (nb[i]) nb[i] = 0;
      2: begin y = ($urandom_range(0, 1) == 0) ? 470 : $urandom_range(468, 1023);
           d = 1 + 2 * $urandom_range(0, 1); end
      default: begin nb[3] = 0; nb[17] = 0; nb[50] = 0; nb[88] = 0; nb[119] = 0; end
    endcase
    l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
    btn_left = l; btn_right = r;
    m_slot = nb;
    nxt_bricks = pack_model();
    nxt_ball_x = 10'(x); nxt_ball_y = 10'(y); nxt_ball_vx = 10'(vx); nxt_ball_vy = 10'(vy);
    nxt_ball_dir = 2'(d);
    m_paddle(l, r);
    miss = (y + 10 > 477) && (d % 2 == 1);
    if (miss) begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_bx = m_board + 40; m_by = 457; m_vx = 0; m_vy = 0; m_dir = 2;
      m_state = (m_lives == 0) ? 5 : 1;
      push_exp();
    end else begin
      m_bx = x; m_by = y; m_vx = vx; m_vy = vy; m_dir = d; m_state = 3;
      push_exp();
      if (abort_at < 0) begin
        cnt = 0;
        foreach (m_slot[i]) if (m_slot[i] != 0) cnt++;
        m_score = (cnt >= 120) ? 0 : 120 - cnt;
        m_state = (cnt == 0) ? 4 : 2;
        push_exp();
      end
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    if (!miss) begin
      n = 0;
      while (state == 3'd3 && n < 600) begin
        if (n == abort_at) begin
          m_reset();
          push_exp();
          rst_n = 1'b0;
          #1;
          chk_rec("midscan_reset", snapshot());
          break;
        end
        // Ticks, buttons and fresh physics during the scan must all be ignored.
        frame_tick = 1'($urandom_range(0, 7) == 0);
        btn_left = 1'($urandom_range(0, 1)); btn_right = 1'($urandom_range(0, 1));
        nxt_bricks = {45{$urandom()}};
        nxt_ball_x = 10'($urandom()); nxt_ball_y = 10'($urandom_range(0, 400));
        step();
        n++;
      end
      frame_tick = 1'b0;
      if (abort_at < 0) chk("scan_latency", n, 480);
    end else begin
      step();
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_rec("reset", snapshot());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // New game with btn_start held: must stop in SERVE.
    m_new_game();
    push_exp();
    btn_start = 1'b1;
    repeat (5) step();
    btn_start = 1'b0;
    step();
    chk("held_start_state", state, 1);

    paddle_ticks(40, 0);
    chk("paddle_floor", board_x, m_board);
    paddle_ticks(80, 1);
    chk("paddle_ceiling", board_x, m_board);
    paddle_ticks(20, 2);
    chk("paddle_random", board_x, m_board);

    serve(1'b1);
    play_frame(3, -1);
    chk("score_five", score, m_score);
    repeat (4) play_frame(0, -1);
    play_frame(2, -1);
    chk("lives_after_miss", lives, m_lives);
    paddle_ticks(5, 2);
    serve(1'b0);
    repeat (2) play_frame(0, -1);
    play_frame(2, -1);
    serve(1'b1);
    play_frame(2, -1);
    chk("over_lives", lives, m_lives);

    // OVER is frozen until a start edge.
    paddle_ticks(3, 1);
    m_board = board_x == m_board ? m_board : m_board;
    chk("over_frozen_score", score, m_score);
    m_state = 0;
    push_exp();
    start_press(1'b0);

    m_new_game();
    push_exp();
    start_press(1'b0);
    serve(1'b0);
    play_frame(1, -1);
    chk("win_score", score, m_score);
    btn_right = 1'b1;
    repeat (3) begin frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); end
    btn_right = 1'b0;
    chk("win_frozen_board", board_x, m_board);

    m_state = 0;
    push_exp();
    start_press(1'b0);
    m_new_game();
    push_exp();
    start_press(1'b0);
    serve(1'b1);
    play_frame(0, 200);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
